// File: rtl/serial_audio_encoder_if.sv
// serial_audio_encoder_if: valid/ready stereo sample stream feeding the encoder
interface serial_audio_encoder_if #(parameter int audio_width = 16);
  logic i_valid;
  logic i_ready;
  logic i_is_left;
  logic [audio_width-1:0] i_audio;
  modport master(output i_valid, output i_is_left, output i_audio, input i_ready);
  modport slave(input i_valid, input i_is_left, input i_audio, output i_ready);
endinterface

// File: rtl/serial_audio_encoder.sv
// serial_audio_encoder: I2S/left-justified transmitter, 64 sclk per frame; SERIAL_AUDIO_ENCODER_UNDERRUN_REPEAT_EN repeats the last sample on underrun
module serial_audio_encoder #(parameter int audio_width = 16) (
  input  logic sclk,
  input  logic reset,
  input  logic is_i2s,
  input  logic lrclk_polarity,
  serial_audio_encoder_if.slave stream,
  output logic lrclk,
  output logic sdout,
  output logic o_underrun
);
  localparam int pad = 32 - audio_width;
  logic [5:0] cnt, cnt_nx;
  logic [audio_width-1:0] hold, left_buf, right_buf, smp;
  logic hold_full, hold_left, left_full, right_full;
  logic ld, ld_left, avail, take, mv_l, mv_r;
  logic [31:0] sr, word;
`ifdef SERIAL_AUDIO_ENCODER_UNDERRUN_REPEAT_EN
  logic [audio_width-1:0] last_l, last_r;
`endif
  assign stream.i_ready = !reset && !hold_full;
  // slot load decision, hold->buffer moves and the MSB-aligned word to load
  always_comb begin
    cnt_nx = cnt + 6'd1;
    ld = cnt_nx[4:0] == 5'd0;
    ld_left = !cnt_nx[5];
    avail = ld_left ? left_full : right_full;
    take = stream.i_valid && stream.i_ready;
    mv_l = hold_full && hold_left && !left_full;
    mv_r = hold_full && !hold_left && !right_full;
`ifdef SERIAL_AUDIO_ENCODER_UNDERRUN_REPEAT_EN
    smp = avail ? (ld_left ? left_buf : right_buf) : (ld_left ? last_l : last_r);
`else
    smp = avail ? (ld_left ? left_buf : right_buf) : '0;
`endif
    word = 32'(smp) << pad;
  end
  // frame counter, serialiser and input buffering; I2S keeps the old word's last bit for p=0
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      cnt <= 6'd63;
      lrclk <= 1'b0;
      sdout <= 1'b0;
      o_underrun <= 1'b0;
      sr <= '0;
      hold <= '0;
      hold_left <= 1'b0;
      hold_full <= 1'b0;
      left_buf <= '0;
      right_buf <= '0;
      left_full <= 1'b0;
      right_full <= 1'b0;
`ifdef SERIAL_AUDIO_ENCODER_UNDERRUN_REPEAT_EN
      last_l <= '0;
      last_r <= '0;
`endif
    end else begin
      cnt <= cnt_nx;
      lrclk <= cnt_nx[5] ^ lrclk_polarity;
      sdout <= (ld && !is_i2s) ? word[31] : sr[31];
      sr <= ld ? (is_i2s ? word : word << 1) : sr << 1;
      o_underrun <= ld && !avail;
      if (take) begin
        hold <= stream.i_audio;
        hold_left <= stream.i_is_left;
      end
      hold_full <= take || (hold_full && !mv_l && !mv_r);
      if (mv_l) left_buf <= hold;
      if (mv_r) right_buf <= hold;
      left_full <= mv_l || (left_full && !(ld && ld_left));
      right_full <= mv_r || (right_full && !(ld && !ld_left));
`ifdef SERIAL_AUDIO_ENCODER_UNDERRUN_REPEAT_EN
      if (ld && avail && ld_left) last_l <= left_buf;
      if (ld && avail && !ld_left) last_r <= right_buf;
`endif
    end
  end
endmodule

// File: tb/tb_serial_audio_encoder.sv
// tb_serial_audio_encoder: directed + random loopback bench with a per-channel scoreboard
module tb_serial_audio_encoder;
  localparam int W = 16;
`ifdef SERIAL_AUDIO_ENCODER_UNDERRUN_REPEAT_EN
  localparam bit repeat_en = 1'b1;
`else
  localparam bit repeat_en = 1'b0;
`endif
  logic sclk = 1'b0, reset = 1'b1, is_i2s = 1'b0, pol = 1'b0;
  logic lrclk, sdout, o_underrun;
  serial_audio_encoder_if #(.audio_width(W)) bus();
  serial_audio_encoder #(.audio_width(W)) dut (
    .sclk(sclk), .reset(reset), .is_i2s(is_i2s), .lrclk_polarity(pol),
    .stream(bus), .lrclk(lrclk), .sdout(sdout), .o_underrun(o_underrun)
  );
  always #5 sclk = ~sclk;
  int total = 0, bad = 0;
  logic [W-1:0] q_l[$], q_r[$];
  logic [W-1:0] last_l = '0, last_r = '0;
  logic [5:0] tcnt = 6'd63;
  logic [31:0] cw = '0;
  logic cl = 1'b0, cu = 1'b0, cv = 1'b0, uf_forbid = 1'b0;

  always @(posedge sclk or posedge reset) tcnt <= reset ? 6'd63 : tcnt + 6'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic finish_slot();
    logic [W-1:0] e;
    if (cu) e = repeat_en ? (cl ? last_l : last_r) : '0;
    else begin
      chk(cl ? "sb_l_nonempty" : "sb_r_nonempty", (cl ? q_l.size() : q_r.size()) != 0, 1);
      e = '0;
      if (cl && q_l.size() != 0) begin e = q_l.pop_front(); last_l = e; end
      if (!cl && q_r.size() != 0) begin e = q_r.pop_front(); last_r = e; end
    end
    chk(cl ? "slot_l" : "slot_r", cw, {e, 16'h0000});
  endtask

  initial forever begin
    @(negedge sclk);
    if (reset) cv = 1'b0;
    else begin
      int p;
      p = int'(tcnt[4:0]);
      chk("lrclk", lrclk, tcnt[5] ^ pol);
      if (uf_forbid) chk("no_underrun", o_underrun, 0);
      if (p == 0) begin
        if (is_i2s) begin
          cw[0] = sdout;
          if (cv) finish_slot();
        end
        cv = 1'b1;
        cl = !tcnt[5];
        cu = o_underrun;
        cw = '0;
        if (!is_i2s) cw[31] = sdout;
      end else if (is_i2s) cw[32-p] = sdout;
      else begin
        cw[31-p] = sdout;
        if (p == 31 && cv) finish_slot();
      end
    end
  end

  task automatic start(input logic i2s, input logic p);
    reset = 1'b1;
    bus.i_valid = 1'b0;
    uf_forbid = 1'b0;
    is_i2s = i2s;
    pol = p;
    repeat (5) @(posedge sclk);
    @(negedge sclk);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_sdout", sdout, 0);
    chk("rst_ready", bus.i_ready, 0);
    chk("rst_underrun", o_underrun, 0);
    q_l.delete();
    q_r.delete();
    last_l = '0;
    last_r = '0;
    reset = 1'b0;
    @(posedge sclk);
    #1;
    chk("ready_after_rst", bus.i_ready, 1);
  endtask

  task automatic push(input logic left, input logic [W-1:0] v);
    int n = 0;
    if (left) q_l.push_back(v);
    else q_r.push_back(v);
    bus.i_valid = 1'b1;
    bus.i_is_left = left;
    bus.i_audio = v;
    while (bus.i_ready !== 1'b1 && n < 300) begin
      @(negedge sclk);
      n++;
    end
    chk("accept_in_time", n < 300, 1);
    @(posedge sclk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_cnt(input logic [5:0] n);
    int k = 0;
    do begin
      @(negedge sclk);
      k++;
    end while (tcnt != n && k < 200);
    chk("wait_cnt", tcnt, n);
  endtask

  task automatic drain();
    int k = 0;
    while ((q_l.size() != 0 || q_r.size() != 0) && k < 400) begin
      @(negedge sclk);
      k++;
    end
    chk("drain", q_l.size() + q_r.size(), 0);
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_is_left = 1'b0;
    bus.i_audio = '0;
    // reset values, then I2S with pol=0
    start(1'b1, 1'b0);
    push(1'b1, 16'hA5F0);
    push(1'b0, 16'h0F0F);
    drain();
    // left-justified, pol=1, single left sample 8001
    start(1'b0, 1'b1);
    push(1'b1, 16'h8001);
    wait_cnt(6'd32);
    wait_cnt(6'd0);
    chk("lj_p0", sdout, 1);
    chk("lj_lrclk_left", lrclk, 1);
    wait_cnt(6'd14);
    chk("lj_p14", sdout, 0);
    wait_cnt(6'd15);
    chk("lj_p15", sdout, 1);
    wait_cnt(6'd16);
    chk("lj_p16", sdout, 0);
    drain();
    // underrun: left only, then one right sample
    start(1'b1, 1'b0);
    push(1'b1, 16'h1111);
    wait_cnt(6'd31);
    chk("uf_before", o_underrun, 0);
    wait_cnt(6'd32);
    chk("uf_at_32", o_underrun, 1);
    wait_cnt(6'd33);
    chk("uf_after", o_underrun, 0);
    wait_cnt(6'd0);
    chk("uf_left_full", o_underrun, 0);
    push(1'b0, 16'h1234);
    drain();
    wait_cnt(6'd0);
    wait_cnt(6'd0);
    wait_cnt(6'd32);
    chk("uf_repeat_slot", o_underrun, 1);
    wait_cnt(6'd1);
    // backpressure: L,L,R back to back at cnt=40
    start(1'b1, 1'b0);
    wait_cnt(6'd40);
    push(1'b1, 16'hC001);
    push(1'b1, 16'hC002);
    @(negedge sclk);
    chk("stall_ready", bus.i_ready, 0);
    push(1'b0, 16'hD003);
    chk("r_after_load", tcnt < 6'd29, 1);
    drain();
    // random loopback, both framings, never starved
    for (int m = 0; m < 2; m++) begin
      start(m == 0, m == 1);
      for (int i = 0; i < 100; i++) begin
        push(1'b1, W'($urandom));
        uf_forbid = 1'b1;
        push(1'b0, W'($urandom));
      end
      uf_forbid = 1'b0;
      drain();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
